// File: rtl/dnn_param_store.sv
// Parameter/activation store: streaming valid/ready load port, 1-cycle registered read port.
// s_ready is high only in LOAD, so the source stalls in IDLE/DONE; reads never stall.
module dnn_param_store #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic        [ADDR_WIDTH-1:0] load_base,
  input  logic        [ADDR_WIDTH-1:0] load_len,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         load_busy,
  output logic                         load_done,
  input  logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         rd_oob
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  wr_ptr, remaining;
  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];
  logic [IW-1:0]          wr_idx, rd_idx;
  logic                   start_acc, wr_en, rd_in_range;

  assign start_acc   = (state == IDLE) && load_start;
  assign wr_en       = (state == LOAD) && s_valid;
  // Reduce the pointer modulo DEPTH so an out-of-range base still lands in the array.
  assign wr_idx      = IW'(32'(wr_ptr) % 32'(DEPTH));
  assign rd_idx      = mem_addr[IW-1:0];
  assign rd_in_range = {1'b0, mem_addr} < (ADDR_WIDTH+1)'(DEPTH);

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = (load_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        s_ready   = 1'b1;
        load_busy = 1'b1;
        if (s_valid && remaining == ADDR_WIDTH'(1)) state_nxt = DONE;
      end
      DONE: begin
        load_busy = 1'b1;
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        wr_ptr    <= load_base;
        remaining <= load_len;
      end else if (wr_en) begin
        wr_ptr    <= (wr_idx == IW'(DEPTH-1)) ? '0 : ADDR_WIDTH'(wr_idx) + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end

  // Array contents survive reset; only the control and read register are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= '0;
    end else if (rd_in_range) begin
      mem_data <= mem[rd_idx];
    end else begin
      mem_data <= '0;
    end
  end

  // An out-of-range read in the same cycle as a load start still leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oob <= 1'b0;
    end else if (!rd_in_range) begin
      rd_oob <= 1'b1;
    end else if (start_acc) begin
      rd_oob <= 1'b0;
    end
  end

endmodule
